// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, frame constants,
// command codes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam int PS2_FRAME_EDGES = 11;
    localparam int PS2_DATA_BITS   = 8;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;

    function automatic logic odd_parity(input logic [7:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data lines into the local clock domain and
// produces a one-cycle strobe on each falling edge of the synchronized clock.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_kclk,
    input  logic i_kdata,
    output logic o_kclk,
    output logic o_kdata,
    output logic o_kclk_fe
);

    logic [SYNC_STAGES-1:0] r_kclk_sync;
    logic [SYNC_STAGES-1:0] r_kdata_sync;
    logic                   r_kclk_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_kclk_sync  <= '1;
            r_kdata_sync <= '1;
            r_kclk_prev  <= 1'b1;
        end else begin
            r_kclk_sync  <= {r_kclk_sync[SYNC_STAGES-2:0], i_kclk};
            r_kdata_sync <= {r_kdata_sync[SYNC_STAGES-2:0], i_kdata};
            r_kclk_prev  <= r_kclk_sync[SYNC_STAGES-1];
        end
    end

    assign o_kclk    = r_kclk_sync[SYNC_STAGES-1];
    assign o_kdata   = r_kdata_sync[SYNC_STAGES-1];
    assign o_kclk_fe = r_kclk_prev & ~r_kclk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with registered open-drain enables.
// Optional frame watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 8700,
`ifdef PS2_HOST_TX_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1305000,
`endif
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_err,
    input  logic       i_kclk_in,
    input  logic       i_kdata_in,
    output logic       o_kclk_oe,
    output logic       o_kdata_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    ps2_tx_state_t r_state, w_state_n;
    logic [8:0]    r_shift, w_shift_n;
    logic [IW-1:0] r_inh_cnt, w_inh_cnt_n;
    logic [3:0]    r_bit_cnt, w_bit_cnt_n, w_bit_inc;
    logic          r_nack, w_nack_n;
    logic          r_kclk_oe, w_kclk_oe_n;
    logic          r_kdata_oe, w_kdata_oe_n;
    logic          w_done, w_err;
    logic          w_kclk, w_kdata, w_fe;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt, w_to_cnt_n;
`endif

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_kclk    (i_kclk_in),
        .i_kdata   (i_kdata_in),
        .o_kclk    (w_kclk),
        .o_kdata   (w_kdata),
        .o_kclk_fe (w_fe)
    );

    assign w_bit_inc = (r_bit_cnt == 4'hF) ? r_bit_cnt : r_bit_cnt + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_nack     <= 1'b0;
            r_kclk_oe  <= 1'b0;
            r_kdata_oe <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_inh_cnt  <= w_inh_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_nack     <= w_nack_n;
            r_kclk_oe  <= w_kclk_oe_n;
            r_kdata_oe <= w_kdata_oe_n;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_to_cnt <= '0;
        else       r_to_cnt <= w_to_cnt_n;
    end
`endif

    // Each falling kclk edge shifts the next frame bit onto the data enable.
    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_inh_cnt_n  = r_inh_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_nack_n     = r_nack;
        w_kclk_oe_n  = r_kclk_oe;
        w_kdata_oe_n = r_kdata_oe;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                w_kclk_oe_n  = 1'b0;
                w_kdata_oe_n = 1'b0;
                if (i_tx_valid) begin
                    w_shift_n   = {odd_parity(i_tx_data), i_tx_data};
                    w_inh_cnt_n = '0;
                    w_bit_cnt_n = '0;
                    w_nack_n    = 1'b0;
                    w_kclk_oe_n = 1'b1;
                    w_state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                w_inh_cnt_n = r_inh_cnt + 1'b1;
                if (r_inh_cnt == IW'(INHIBIT_CYCLES - 2))
                    w_kdata_oe_n = 1'b1;
                if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    w_kclk_oe_n  = 1'b0;
                    w_kdata_oe_n = 1'b1;
                    w_state_n    = REQ;
                end
            end
            REQ, DATA: begin
                if (w_fe) begin
                    w_kdata_oe_n = ~r_shift[0];
                    w_shift_n    = r_shift >> 1;
                    w_bit_cnt_n  = w_bit_inc;
                    if (r_state == REQ)
                        w_state_n = DATA;
                    else if (r_bit_cnt == 4'(PS2_DATA_BITS - 1))
                        w_state_n = PARITY;
                end
            end
            PARITY: begin
                if (w_fe) begin
                    w_kdata_oe_n = ~r_shift[0];
                    w_bit_cnt_n  = w_bit_inc;
                    w_state_n    = STOP;
                end
            end
            STOP: begin
                if (w_fe) begin
                    w_kdata_oe_n = 1'b0;
                    w_bit_cnt_n  = w_bit_inc;
                    w_state_n    = ACK;
                end
            end
            ACK: begin
                if (w_fe) begin
                    w_nack_n    = w_kdata;
                    w_bit_cnt_n = w_bit_inc;
                    w_state_n   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_kclk && w_kdata) begin
                    w_done    = ~r_nack;
                    w_err     = r_nack;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog runs from the first REQ cycle; INHIBIT keeps it at zero.
        w_to_cnt_n = (r_state == IDLE || r_state == INHIBIT) ? '0 : r_to_cnt + 1'b1;
        if (r_state != IDLE && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_to_cnt_n   = '0;
            w_kclk_oe_n  = 1'b0;
            w_kdata_oe_n = 1'b0;
            w_done       = 1'b0;
            w_err        = 1'b1;
            w_state_n    = IDLE;
        end
`endif
    end

    assign o_tx_ready = (r_state == IDLE);
    assign o_tx_busy  = (r_state != IDLE);
    assign o_tx_done  = w_done;
    assign o_tx_err   = w_err;
    assign o_kclk_oe  = r_kclk_oe;
    assign o_kdata_oe = r_kdata_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed self-checking bench for ps2_host_tx with a simple PS/2 device model
// on open-drain lines; the watchdog check runs when PS2_HOST_TX_TIMEOUT_EN is set.
module tb_ps2_host_tx;

    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady, txBusy, txDone, txErr;
    logic       kclkOe, kdataOe;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;
    logic       kclkLine, kdataLine;

    int testsRun = 0;
    int testsFailed = 0;
    int doneSeen = 0;
    int errSeen = 0;
    int pulseWhileReady = 0;

    assign kclkLine  = devClk & ~kclkOe;
    assign kdataLine = devData & ~kdataOe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(10),
`ifdef PS2_HOST_TX_TIMEOUT_EN
        .TIMEOUT_CYCLES(500),
`endif
        .SYNC_STAGES(2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tx_data  (txData),
        .i_tx_valid (txValid),
        .o_tx_ready (txReady),
        .o_tx_busy  (txBusy),
        .o_tx_done  (txDone),
        .o_tx_err   (txErr),
        .i_kclk_in  (kclkLine),
        .i_kdata_in (kdataLine),
        .o_kclk_oe  (kclkOe),
        .o_kdata_oe (kdataOe)
    );

    // Completion pulses are tallied continuously; tests compare before/after deltas.
    always @(negedge clk) begin
        if (txDone) doneSeen++;
        if (txErr) errSeen++;
        if ((txDone || txErr) && txReady) pulseWhileReady++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Requests one byte, optionally spams a second request during INHIBIT,
    // then plays the keyboard: 11 clock pulses, sampling the line while high.
    task automatic applyStimulus(input logic [7:0] data, input logic ackIt, input logic spamBusy,
                                 output logic [9:0] seen, output int inhCycles,
                                 output logic startBeforeRelease, output logic readyTimedOut);
        int n;
        seen = '0;
        inhCycles = 0;
        startBeforeRelease = 1'b0;
        @(negedge clk);
        txData = data;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        if (spamBusy) begin
            txData = 8'hFF;
            txValid = 1'b1;
        end
        while (kclkOe && inhCycles < 1000) begin
            inhCycles++;
            startBeforeRelease = kdataOe;
            @(negedge clk);
        end
        txValid = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ackIt) devData = 1'b0;
            repeat (4) @(negedge clk);
            devClk = 1'b0;
            repeat (HALF) @(negedge clk);
            devClk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            if (i < 10) seen[i] = kdataLine;
            repeat (HALF / 2) @(negedge clk);
        end
        devData = 1'b1;
        n = 0;
        while (!txReady && n < 2000) begin
            n++;
            @(negedge clk);
        end
        readyTimedOut = !txReady;
    endtask

    initial begin
        logic [9:0] seen;
        int         inh;
        logic       startLow;
        logic       tmo;
        int         doneBefore;
        int         errBefore;
        int         idleOe;

        $display("[TB] start");
        txValid = 1'b1;
        txData = 8'hED;
        repeat (3) @(negedge clk);
        checkOutput("reset_kclk_oe", 32'(kclkOe), 32'd0);
        checkOutput("reset_kdata_oe", 32'(kdataOe), 32'd0);
        checkOutput("reset_ready", 32'(txReady), 32'd1);
        checkOutput("reset_busy", 32'(txBusy), 32'd0);
        checkOutput("reset_pulses", 32'(doneSeen + errSeen), 32'd0);
        txValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reassert reset part-way through INHIBIT: lines must release at once.
        @(negedge clk);
        txData = 8'hED;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("inhibit_kclk_oe", 32'(kclkOe), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_kclk_oe", 32'(kclkOe), 32'd0);
        checkOutput("midreset_ready", 32'(txReady), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        doneBefore = doneSeen;
        errBefore = errSeen;
        applyStimulus(8'hED, 1'b1, 1'b0, seen, inh, startLow, tmo);
        checkOutput("ed_inhibit_cycles", 32'(inh), 32'd10);
        checkOutput("ed_start_before_release", 32'(startLow), 32'd1);
        checkOutput("ed_bits", 32'(seen), 32'h3ED);
        checkOutput("ed_ready_return", 32'(tmo), 32'd0);
        checkOutput("ed_done_count", 32'(doneSeen - doneBefore), 32'd1);
        checkOutput("ed_err_count", 32'(errSeen - errBefore), 32'd0);

        doneBefore = doneSeen;
        applyStimulus(8'h02, 1'b1, 1'b1, seen, inh, startLow, tmo);
        checkOutput("busy_02_bits", 32'(seen), 32'h202);
        checkOutput("busy_02_done", 32'(doneSeen - doneBefore), 32'd1);
        idleOe = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (kclkOe || txBusy) idleOe++;
        end
        checkOutput("busy_ff_ignored", 32'(idleOe), 32'd0);

        applyStimulus(8'h00, 1'b1, 1'b0, seen, inh, startLow, tmo);
        checkOutput("zero_bits", 32'(seen), 32'h300);

        doneBefore = doneSeen;
        errBefore = errSeen;
        applyStimulus(8'hF4, 1'b0, 1'b0, seen, inh, startLow, tmo);
        checkOutput("nack_bits", 32'(seen), 32'h2F4);
        checkOutput("nack_err_count", 32'(errSeen - errBefore), 32'd1);
        checkOutput("nack_done_count", 32'(doneSeen - doneBefore), 32'd0);
        checkOutput("nack_ready_return", 32'(tmo), 32'd0);
        checkOutput("pulse_while_ready", 32'(pulseWhileReady), 32'd0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        begin
            int k;
            repeat (5) @(negedge clk);
            txData = 8'hFF;
            txValid = 1'b1;
            @(negedge clk);
            txValid = 1'b0;
            k = 0;
            while (kclkOe && k < 1000) begin
                k++;
                @(negedge clk);
            end
            k = 1;
            while (!txErr && k < 2000) begin
                k++;
                @(negedge clk);
            end
            checkOutput("timeout_cycle", 32'(k), 32'd500);
            @(negedge clk);
            checkOutput("timeout_kdata_oe", 32'(kdataOe), 32'd0);
            checkOutput("timeout_ready", 32'(txReady), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
